// File: rtl/packet_rx_deframer_if.sv
// Word-stream input and decoded-frame output of the receive deframer.
// The deframer sits on the master side; the radio source and packet consumer use the slave side.
interface packet_rx_deframer_if #(
    parameter int WORD_WIDTH = 16
);
    logic [WORD_WIDTH-1:0] myNodeID;
    logic [WORD_WIDTH-1:0] rx_data;
    logic                  rx_valid;
    logic                  rx_ready;
    logic                  pkt_valid;
    logic                  pkt_ready;
    logic [2:0]            fPacketType;
    logic [WORD_WIDTH-1:0] fSourceID;
    logic [WORD_WIDTH-1:0] fDestinationID;
    logic [WORD_WIDTH-1:0] fSourceHops;
    logic [WORD_WIDTH-1:0] fQValue;
    logic [WORD_WIDTH-1:0] fEnergyLeft;
    logic [WORD_WIDTH-1:0] fHopsFromCH;
    logic [WORD_WIDTH-1:0] fChosenCH;
    logic [WORD_WIDTH-1:0] fTimeslot;
    logic                  iAmDestination;
    logic [7:0]            err_cnt;

    modport master (
        input  myNodeID, rx_data, rx_valid, pkt_ready,
        output rx_ready, pkt_valid, fPacketType, fSourceID, fDestinationID,
               fSourceHops, fQValue, fEnergyLeft, fHopsFromCH, fChosenCH,
               fTimeslot, iAmDestination, err_cnt
    );

    modport slave (
        output myNodeID, rx_data, rx_valid, pkt_ready,
        input  rx_ready, pkt_valid, fPacketType, fSourceID, fDestinationID,
               fSourceHops, fQValue, fEnergyLeft, fHopsFromCH, fChosenCH,
               fTimeslot, iAmDestination, err_cnt
    );
endinterface

// File: rtl/packet_rx_deframer.sv
// Hunts for a frame header in the radio word stream, collects a 10-word frame, verifies its
// XOR checksum and presents the decoded fields under a valid/ready handshake.
module packet_rx_deframer #(
    parameter int          WORD_WIDTH   = 16,
    parameter logic [12:0] SYNC_PATTERN = 13'h0A5C,
    parameter int          IDLE_TIMEOUT = 32
) (
    input logic                  clk,
    input logic                  rst,
    packet_rx_deframer_if.master bus
);

    localparam int GAP_W = $clog2(IDLE_TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        BODY,
        CHECK,
        HOLD
    } stateT;

    stateT                 state;
    logic [3:0]            idx;
    logic [WORD_WIDTH-1:0] chk;
    logic [GAP_W-1:0]      gapCnt;
    logic                  rxReady;
    logic                  pktValid;
    logic                  iAmDest;
    logic [7:0]            errCnt;
    logic [2:0]            pktType;
    logic [WORD_WIDTH-1:0] srcId;
    logic [WORD_WIDTH-1:0] destId;
    logic [WORD_WIDTH-1:0] srcHops;
    logic [WORD_WIDTH-1:0] qValue;
    logic [WORD_WIDTH-1:0] energyLeft;
    logic [WORD_WIDTH-1:0] hopsFromCh;
    logic [WORD_WIDTH-1:0] chosenCh;
    logic [WORD_WIDTH-1:0] timeslot;
    logic                  xfer;

    assign xfer = bus.rx_valid & rxReady;

    function automatic logic [7:0] satInc(input logic [7:0] v);
        return (v == 8'hFF) ? 8'hFF : v + 8'd1;
    endfunction

    // Single FSM; rx_ready is registered, so it is dropped on the same edge that enters CHECK.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= 4'd0;
            chk        <= '0;
            gapCnt     <= '0;
            rxReady    <= 1'b1;
            pktValid   <= 1'b0;
            iAmDest    <= 1'b0;
            errCnt     <= 8'd0;
            pktType    <= 3'b111;
            srcId      <= '0;
            destId     <= '0;
            srcHops    <= '0;
            qValue     <= '0;
            energyLeft <= '0;
            hopsFromCh <= '0;
            chosenCh   <= '0;
            timeslot   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (xfer && (bus.rx_data[12:0] == SYNC_PATTERN)) begin
                        pktType <= bus.rx_data[15:13];
                        chk     <= bus.rx_data;
                        idx     <= 4'd1;
                        gapCnt  <= '0;
                        state   <= BODY;
                    end
                end

                BODY: begin
                    if (xfer) begin
                        gapCnt <= '0;
                        if (idx == 4'd9) begin
                            idx <= 4'd0;
                            if (bus.rx_data == chk) begin
                                rxReady <= 1'b0;
                                state   <= CHECK;
                            end else begin
                                errCnt <= satInc(errCnt);
                                state  <= IDLE;
                            end
                        end else begin
                            case (idx)
                                4'd1:    srcId      <= bus.rx_data;
                                4'd2:    destId     <= bus.rx_data;
                                4'd3:    srcHops    <= bus.rx_data;
                                4'd4:    qValue     <= bus.rx_data;
                                4'd5:    energyLeft <= bus.rx_data;
                                4'd6:    hopsFromCh <= bus.rx_data;
                                4'd7:    chosenCh   <= bus.rx_data;
                                4'd8:    timeslot   <= bus.rx_data;
                                default: ;
                            endcase
                            chk <= chk ^ bus.rx_data;
                            idx <= idx + 4'd1;
                        end
                    end else if (gapCnt == GAP_W'(IDLE_TIMEOUT - 1)) begin
                        // The IDLE_TIMEOUT-th consecutive empty cycle abandons the frame.
                        errCnt <= satInc(errCnt);
                        idx    <= 4'd0;
                        gapCnt <= '0;
                        state  <= IDLE;
                    end else begin
                        gapCnt <= gapCnt + GAP_W'(1);
                    end
                end

                CHECK: begin
                    if ((srcId == bus.myNodeID) || (pktType == 3'b110) || (pktType == 3'b111)) begin
                        rxReady <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        iAmDest  <= (destId == bus.myNodeID);
                        pktValid <= 1'b1;
                        state    <= HOLD;
                    end
                end

                HOLD: begin
                    if (bus.pkt_ready) begin
                        pktValid <= 1'b0;
                        iAmDest  <= 1'b0;
                        rxReady  <= 1'b1;
                        state    <= IDLE;
                    end
                end

                default: begin
                    rxReady  <= 1'b1;
                    pktValid <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

    assign bus.rx_ready       = rxReady;
    assign bus.pkt_valid      = pktValid;
    assign bus.iAmDestination = iAmDest;
    assign bus.err_cnt        = errCnt;
    assign bus.fPacketType    = pktType;
    assign bus.fSourceID      = srcId;
    assign bus.fDestinationID = destId;
    assign bus.fSourceHops    = srcHops;
    assign bus.fQValue        = qValue;
    assign bus.fEnergyLeft    = energyLeft;
    assign bus.fHopsFromCH    = hopsFromCh;
    assign bus.fChosenCH      = chosenCh;
    assign bus.fTimeslot      = timeslot;

endmodule

// File: tb/tb_packet_rx_deframer.sv
// Directed bench for packet_rx_deframer: frames are built with their own XOR checksum and
// delivered frames are checked against a scoreboard queue filled when each frame is sent.
module tb_packet_rx_deframer;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    packet_rx_deframer_if #(.WORD_WIDTH(16)) bus ();

    packet_rx_deframer #(
        .WORD_WIDTH  (16),
        .SYNC_PATTERN(13'h0A5C),
        .IDLE_TIMEOUT(32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic [2:0]  ptype;
        logic [15:0] src;
        logic [15:0] dest;
        logic [15:0] hops;
        logic [15:0] q;
        logic [15:0] energy;
        logic [15:0] hopsCH;
        logic [15:0] chosen;
        logic [15:0] slot;
        logic        iAmDest;
    } pktT;

    pktT sbQueue[$];
    int  errors = 0;
    int  checks = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic sendWord(input logic [15:0] w);
        int waitCycles = 0;
        bus.rx_data  = w;
        bus.rx_valid = 1'b1;
        while (bus.rx_ready !== 1'b1 && waitCycles < 50) begin
            @(posedge clk);
            #1;
            waitCycles++;
        end
        if (waitCycles >= 50) begin
            checks++;
            errors++;
            $error("[TB] FAIL rxReadyWait observed=0 expected=1");
        end
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
    endtask

    // Sends the first nWords words of the frame for p; corrupt flips bit 0 of the checksum word.
    task automatic applyStimulus(input pktT p, input bit corrupt, input int nWords);
        logic [15:0] f [10];
        logic [15:0] c;
        f[0] = {p.ptype, 13'h0A5C};
        f[1] = p.src;
        f[2] = p.dest;
        f[3] = p.hops;
        f[4] = p.q;
        f[5] = p.energy;
        f[6] = p.hopsCH;
        f[7] = p.chosen;
        f[8] = p.slot;
        c = 16'h0000;
        for (int i = 0; i < 9; i++) c = c ^ f[i];
        f[9] = corrupt ? (c ^ 16'h0001) : c;
        for (int i = 0; i < nWords; i++) sendWord(f[i]);
    endtask

    task automatic compareFields(input string tag, input pktT e);
        checkOutput({tag, ".type"},   bus.fPacketType,    e.ptype);
        checkOutput({tag, ".src"},    bus.fSourceID,      e.src);
        checkOutput({tag, ".dest"},   bus.fDestinationID, e.dest);
        checkOutput({tag, ".hops"},   bus.fSourceHops,    e.hops);
        checkOutput({tag, ".q"},      bus.fQValue,        e.q);
        checkOutput({tag, ".energy"}, bus.fEnergyLeft,    e.energy);
        checkOutput({tag, ".hopsCH"}, bus.fHopsFromCH,    e.hopsCH);
        checkOutput({tag, ".chosen"}, bus.fChosenCH,      e.chosen);
        checkOutput({tag, ".slot"},   bus.fTimeslot,      e.slot);
        checkOutput({tag, ".iAmDst"}, bus.iAmDestination, e.iAmDest);
    endtask

    // Called right after the checksum word transfer: pkt_valid must be low now and high one edge later.
    task automatic receivePacket(input string tag, input int holdCycles);
        pktT e;
        checkOutput({tag, ".validEarly"}, bus.pkt_valid, 1'b0);
        @(posedge clk);
        #1;
        checkOutput({tag, ".validN+2"}, bus.pkt_valid, 1'b1);
        checkOutput({tag, ".sbPending"}, sbQueue.size(), 1);
        if (sbQueue.size() > 0) begin
            e = sbQueue.pop_front();
            compareFields(tag, e);
            for (int i = 0; i < holdCycles; i++) begin
                @(posedge clk);
                #1;
                checkOutput({tag, ".holdValid"}, bus.pkt_valid, 1'b1);
                checkOutput({tag, ".holdRxReady"}, bus.rx_ready, 1'b0);
                checkOutput({tag, ".holdQ"}, bus.fQValue, e.q);
            end
        end
        bus.pkt_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.pkt_ready = 1'b0;
        checkOutput({tag, ".validCleared"}, bus.pkt_valid, 1'b0);
    endtask

    task automatic expectDrop(input string tag);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            checkOutput({tag, ".noValid"}, bus.pkt_valid, 1'b0);
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        pktT hb, data, good, echo, badType, misc;

        hb      = '{ptype: 3'b000, src: 16'd0, dest: 16'hFFFF, hops: 16'd3, q: 16'd0,
                    energy: 16'd0, hopsCH: 16'd0, chosen: 16'd0, slot: 16'd0, iAmDest: 1'b0};
        data    = '{ptype: 3'b101, src: 16'd35, dest: 16'd12, hops: 16'd4, q: 16'd3000,
                    energy: 16'd7000, hopsCH: 16'd2, chosen: 16'd17, slot: 16'h0A5C, iAmDest: 1'b1};
        good    = '{ptype: 3'b010, src: 16'd7, dest: 16'd9, hops: 16'd1, q: 16'h1234,
                    energy: 16'h00FF, hopsCH: 16'd5, chosen: 16'd7, slot: 16'd3, iAmDest: 1'b0};
        echo    = '{ptype: 3'b001, src: 16'd12, dest: 16'd12, hops: 16'd1, q: 16'd1,
                    energy: 16'd1, hopsCH: 16'd1, chosen: 16'd1, slot: 16'd1, iAmDest: 1'b1};
        badType = '{ptype: 3'b110, src: 16'd40, dest: 16'd12, hops: 16'd2, q: 16'd2,
                    energy: 16'd2, hopsCH: 16'd2, chosen: 16'd2, slot: 16'd2, iAmDest: 1'b1};
        misc    = '{ptype: 3'b011, src: 16'hBEEF, dest: 16'h0A5C, hops: 16'hFFFF, q: 16'h8000,
                    energy: 16'h0001, hopsCH: 16'h2A5C, chosen: 16'h00C0, slot: 16'h7FFF, iAmDest: 1'b0};

        rst           = 1'b1;
        bus.myNodeID  = 16'd12;
        bus.rx_data   = 16'h0000;
        bus.rx_valid  = 1'b0;
        bus.pkt_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset.rxReady", bus.rx_ready, 1'b1);
        checkOutput("reset.pktValid", bus.pkt_valid, 1'b0);
        checkOutput("reset.iAmDst", bus.iAmDestination, 1'b0);
        checkOutput("reset.errCnt", bus.err_cnt, 8'd0);
        checkOutput("reset.type", bus.fPacketType, 3'b111);
        checkOutput("reset.src", bus.fSourceID, 16'd0);
        rst = 1'b0;

        $display("[TB] heartbeat frame");
        sbQueue.push_back(hb);
        applyStimulus(hb, 1'b0, 10);
        receivePacket("heartbeat", 0);

        $display("[TB] data frame with 5-cycle backpressure");
        sbQueue.push_back(data);
        applyStimulus(data, 1'b0, 10);
        receivePacket("data", 5);

        $display("[TB] corrupt checksum then good frame");
        applyStimulus(good, 1'b1, 10);
        checkOutput("corrupt.errCnt", bus.err_cnt, 8'd1);
        expectDrop("corrupt");
        sbQueue.push_back(good);
        applyStimulus(good, 1'b0, 10);
        receivePacket("afterCorrupt", 0);

        $display("[TB] stall after W4, echo frame, reserved type");
        applyStimulus(data, 1'b0, 5);
        repeat (31) @(posedge clk);
        #1;
        checkOutput("stall31.errCnt", bus.err_cnt, 8'd1);
        @(posedge clk);
        #1;
        checkOutput("stall32.errCnt", bus.err_cnt, 8'd2);
        applyStimulus(echo, 1'b0, 10);
        expectDrop("echo");
        checkOutput("echo.errCnt", bus.err_cnt, 8'd2);
        applyStimulus(badType, 1'b0, 10);
        expectDrop("type110");
        checkOutput("type110.errCnt", bus.err_cnt, 8'd2);

        $display("[TB] garbage words then frame");
        sendWord(16'h1234);
        sendWord(16'hFFFF);
        sendWord(16'h0A5B);
        sbQueue.push_back(misc);
        applyStimulus(misc, 1'b0, 10);
        receivePacket("afterGarbage", 0);
        checkOutput("garbage.errCnt", bus.err_cnt, 8'd2);

        $display("[TB] reset mid-frame");
        applyStimulus(data, 1'b0, 6);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("midReset.rxReady", bus.rx_ready, 1'b1);
        checkOutput("midReset.pktValid", bus.pkt_valid, 1'b0);
        checkOutput("midReset.iAmDst", bus.iAmDestination, 1'b0);
        checkOutput("midReset.errCnt", bus.err_cnt, 8'd0);
        checkOutput("midReset.type", bus.fPacketType, 3'b111);
        checkOutput("midReset.src", bus.fSourceID, 16'd0);
        checkOutput("midReset.dest", bus.fDestinationID, 16'd0);
        sbQueue.push_back(data);
        applyStimulus(data, 1'b0, 10);
        receivePacket("afterReset", 0);

        $display("[TB] 256 corrupt frames");
        for (int n = 1; n <= 256; n++) begin
            applyStimulus(good, 1'b1, 10);
            if (n == 1)   checkOutput("sat.first", bus.err_cnt, 8'd1);
            if (n == 254) checkOutput("sat.254", bus.err_cnt, 8'hFE);
            if (n == 255) checkOutput("sat.255", bus.err_cnt, 8'hFF);
        end
        checkOutput("sat.256", bus.err_cnt, 8'hFF);
        checkOutput("sat.noValid", bus.pkt_valid, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
